// File: rtl/com_bus_pkg.sv
// Shared types and default sizing for the common-bus round-robin arbiter.
package com_bus_pkg;

  localparam int unsigned NumProcDef  = 8;
  localparam int unsigned NumSnoopDef = 4;

  typedef enum logic [1:0] {
    StIdle,
    StProc,
    StSnoop,
    StTurn
  } bus_state_e;

endpackage

// File: rtl/com_bus_rr_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after i_ptr, as one-hot plus index.
module rr_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IdxW-1:0] w_off;
  logic [IdxW:0]   w_sum;

  // Bit k of w_rot is request (i_ptr + k) mod N.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IdxW'(i);
        o_valid = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IdxW + 1)'(N)) ? IdxW'(w_sum - (IdxW + 1)'(N)) : w_sum[IdxW-1:0];

  always_comb begin
    o_gnt = '0;
    if (o_valid) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/com_bus_rr_arbiter.sv
// Common-bus arbiter: round-robin processor grants with nested snoop/memory grants.
// Optional watchdog enabled by defining COM_BUS_TIMEOUT_EN.
module com_bus_rr_arbiter
  import com_bus_pkg::*;
#(
  parameter int unsigned NUM_PROC       = NumProcDef,
  parameter int unsigned NUM_SNOOP      = NumSnoopDef,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PROC-1:0]         Com_Bus_Req_proc,
  output logic [NUM_PROC-1:0]         Com_Bus_Gnt_proc,
  input  logic [NUM_SNOOP-1:0]        Com_Bus_Req_snoop,
  output logic [NUM_SNOOP-1:0]        Com_Bus_Gnt_snoop,
  input  logic                        Mem_snoop_req,
  output logic                        Mem_snoop_gnt,
  output logic [$clog2(NUM_PROC)-1:0] Bus_owner,
  output logic                        Bus_busy,
  output logic                        Bus_timeout
);

  localparam int unsigned PW = $clog2(NUM_PROC);
  localparam int unsigned SW = $clog2(NUM_SNOOP);

  bus_state_e r_state, w_state_d;
  logic [NUM_PROC-1:0]  r_gnt_proc, w_gnt_proc_d;
  logic [NUM_SNOOP-1:0] r_gnt_snoop, w_gnt_snoop_d;
  logic                 r_gnt_mem, w_gnt_mem_d;
  logic [PW-1:0]        r_owner, w_owner_d;
  logic [PW-1:0]        r_rr_ptr, w_rr_ptr_d;
  logic [SW-1:0]        r_snoop_ptr, w_snoop_ptr_d;

  logic [NUM_PROC-1:0]  w_proc_onehot;
  logic [PW-1:0]        w_proc_idx;
  logic                 w_proc_valid;
  logic [NUM_SNOOP-1:0] w_snoop_onehot;
  logic [SW-1:0]        w_snoop_idx;
  logic                 w_snoop_valid;

  logic w_owner_req;
  logic w_any_snoop;
  logic w_snoop_held;

  rr_pick #(
    .N    (NUM_PROC),
    .IdxW (PW)
  ) u_proc_pick (
    .i_req   (Com_Bus_Req_proc),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_proc_onehot),
    .o_idx   (w_proc_idx),
    .o_valid (w_proc_valid)
  );

  rr_pick #(
    .N    (NUM_SNOOP),
    .IdxW (SW)
  ) u_snoop_pick (
    .i_req   (Com_Bus_Req_snoop),
    .i_ptr   (r_snoop_ptr),
    .o_gnt   (w_snoop_onehot),
    .o_idx   (w_snoop_idx),
    .o_valid (w_snoop_valid)
  );

  assign w_owner_req  = |(Com_Bus_Req_proc & r_gnt_proc);
  assign w_any_snoop  = (|Com_Bus_Req_snoop) | Mem_snoop_req;
  assign w_snoop_held = (|(Com_Bus_Req_snoop & r_gnt_snoop)) | (Mem_snoop_req & r_gnt_mem);

`ifdef COM_BUS_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_wdog, w_wdog_d;
  logic        r_timeout, w_timeout_d;
  logic        w_gnt_change;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_gnt_proc_d  = r_gnt_proc;
    w_gnt_snoop_d = r_gnt_snoop;
    w_gnt_mem_d   = r_gnt_mem;
    w_owner_d     = r_owner;
    w_rr_ptr_d    = r_rr_ptr;
    w_snoop_ptr_d = r_snoop_ptr;

    unique case (r_state)
      StIdle: begin
        if (w_proc_valid) begin
          w_gnt_proc_d = w_proc_onehot;
          w_owner_d    = w_proc_idx;
          w_rr_ptr_d   = (w_proc_idx == PW'(NUM_PROC - 1)) ? '0 : w_proc_idx + 1'b1;
          w_state_d    = StProc;
        end
      end
      StProc: begin
        if (!w_owner_req) begin
          w_gnt_proc_d = '0;
          w_state_d    = StTurn;
        end else if (w_any_snoop) begin
          w_state_d = StSnoop;
          // Cache snoops take priority; memory only when none is pending.
          if (w_snoop_valid) begin
            w_gnt_snoop_d = w_snoop_onehot;
            w_snoop_ptr_d = (w_snoop_idx == SW'(NUM_SNOOP - 1)) ? '0 : w_snoop_idx + 1'b1;
          end else begin
            w_gnt_mem_d = 1'b1;
          end
        end
      end
      StSnoop: begin
        if (!w_snoop_held) begin
          w_gnt_snoop_d = '0;
          w_gnt_mem_d   = 1'b0;
          if (w_owner_req) begin
            w_state_d = StProc;
          end else begin
            w_gnt_proc_d = '0;
            w_state_d    = StTurn;
          end
        end
      end
      StTurn: begin
        w_gnt_proc_d  = '0;
        w_gnt_snoop_d = '0;
        w_gnt_mem_d   = 1'b0;
        w_state_d     = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

`ifdef COM_BUS_TIMEOUT_EN
    w_timeout_d  = 1'b0;
    w_wdog_d     = r_wdog;
    w_gnt_change = (w_gnt_proc_d != r_gnt_proc) || (w_gnt_snoop_d != r_gnt_snoop) ||
                   (w_gnt_mem_d != r_gnt_mem);
    if (w_gnt_change) begin
      w_wdog_d = '0;
    end else if (r_state == StProc || r_state == StSnoop) begin
      if (r_wdog == TimeoutLimit - 16'd1) begin
        w_timeout_d   = 1'b1;
        w_wdog_d      = '0;
        w_gnt_proc_d  = '0;
        w_gnt_snoop_d = '0;
        w_gnt_mem_d   = 1'b0;
        w_state_d     = StTurn;
      end else begin
        w_wdog_d = r_wdog + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_gnt_proc  <= '0;
      r_gnt_snoop <= '0;
      r_gnt_mem   <= 1'b0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_snoop_ptr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_gnt_proc  <= w_gnt_proc_d;
      r_gnt_snoop <= w_gnt_snoop_d;
      r_gnt_mem   <= w_gnt_mem_d;
      r_owner     <= w_owner_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_snoop_ptr <= w_snoop_ptr_d;
    end
  end

`ifdef COM_BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign Bus_timeout = r_timeout;
`else
  assign Bus_timeout = 1'b0;
`endif

  assign Com_Bus_Gnt_proc  = r_gnt_proc;
  assign Com_Bus_Gnt_snoop = r_gnt_snoop;
  assign Mem_snoop_gnt     = r_gnt_mem;
  assign Bus_owner         = r_owner;
  assign Bus_busy          = |r_gnt_proc;

endmodule

// File: doc/com_bus_rr_arbiter.md
COM_BUS_RR_ARBITER -- requirements
Module: com_bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PROC, default 8: processor-side requesters (4 DL + 4 IL).
REQ-002 SHALL have parameter NUM_SNOOP, default 4: snoop-side requesters (4 DL).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit (used only under REQ-026).
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  bus clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 Com_Bus_Req_proc  input  NUM_PROC  processor-side bus requests, level, held until the transaction is done.
REQ-008 Com_Bus_Gnt_proc  output  NUM_PROC  processor-side grants, one-hot-or-zero.
REQ-009 Com_Bus_Req_snoop  input  NUM_SNOOP  snoop flush/supply requests.
REQ-010 Com_Bus_Gnt_snoop  output  NUM_SNOOP  snoop grants, one-hot-or-zero.
REQ-011 Mem_snoop_req  input  1  memory write-back request during a snoop.
REQ-012 Mem_snoop_gnt  output  1  memory snoop grant.
REQ-013 Bus_owner  output  $clog2(NUM_PROC)  index of current processor-side owner; valid while Bus_busy.
REQ-014 Bus_busy  output  1  high while any processor grant is asserted.
REQ-015 Bus_timeout  output  1  one-cycle pulse on watchdog expiry (tied 0 without REQ-026).

Function
REQ-016 SHALL implement states IDLE, PROC, SNOOP, TURN; all grant outputs registered.
REQ-017 IDLE: if any Com_Bus_Req_proc high, SHALL select the round-robin winner at or after rr_ptr, assert its grant next cycle, enter PROC; else stay IDLE.
REQ-018 On entering PROC SHALL set rr_ptr to winner+1, wrapping NUM_PROC-1 to 0.
REQ-019 PROC: owner request low -> drop grant next cycle, enter TURN; owner request high and any snoop request (cache or memory) -> enter SNOOP, proc grant remains asserted.
REQ-020 SNOOP: SHALL grant exactly one snoop requester, cache snoops round-robin via separate snoop_ptr, Mem_snoop_req only when no cache snoop request pending; grant held until that request drops.
REQ-021 SNOOP exit: granted snoop request low -> drop snoop grant next cycle, return to PROC if proc owner request still high, else TURN.
REQ-022 TURN: exactly one cycle with all grants low, then IDLE; requests arriving in TURN are evaluated in IDLE.
REQ-023 Non-owner proc requests SHALL never preempt; a request dropping before grant SHALL be ignored without error.
REQ-024 Simultaneous requests: lowest index at or after pointer wins; no requester waits more than NUM_PROC-1 grants.

Reset
REQ-025 rst SHALL immediately force all grants, Bus_busy, Bus_timeout, Bus_owner to 0, rr_ptr and snoop_ptr to 0, state IDLE, including mid-PROC or mid-SNOOP.

Configuration
REQ-026 COM_BUS_TIMEOUT_EN defined: 16-bit counter clears on each grant change, increments while in PROC/SNOOP; reaching TIMEOUT_CYCLES SHALL pulse Bus_timeout, drop all grants, enter TURN.
REQ-027 COM_BUS_TIMEOUT_EN undefined: no counter, Bus_timeout constant 0, grants held indefinitely.

Structure
REQ-028 Shared package com_bus_pkg SHALL hold the state enum type and default NUM_PROC/NUM_SNOOP constants.
REQ-029 One sub-module rr_pick (request vector, pointer -> one-hot winner, valid), instantiated twice (proc, snoop).

Verification
REQ-030 Reset, then Com_Bus_Req_proc=8'h01 -> Com_Bus_Gnt_proc=8'h01 next cycle, Bus_owner=0, Bus_busy=1.
REQ-031 Com_Bus_Req_proc=8'h81 held, each released after grant, re-raised -> grant order 0,7,0,7 with one all-zero TURN cycle between.
REQ-032 Owner 2 granted, Com_Bus_Req_snoop=4'b1010 -> Gnt_snoop=4'b0010 then 4'b1000, Gnt_proc stays 8'h04 throughout.
REQ-033 Owner granted, Mem_snoop_req=1 and Com_Bus_Req_snoop=4'b0001 together -> cache snoop 0 first, Mem_snoop_gnt only after it releases.
REQ-034 rst asserted mid-SNOOP -> all grants 0 same cycle; after release, req 8'h10 -> grant 8'h10 (pointer restarted at 0).
REQ-035 With COM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner holds request 20 cycles -> Bus_timeout pulses once at cycle 16, grants drop.
